// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchroniser, tick-sampled stability filter and press/release/long-press pulses
module button_debouncer #(
  parameter int CHANNELS         = 3,
  parameter int TICK_DIV         = 8192,
  parameter int STABLE_SAMPLES   = 4,
  parameter int LONG_PRESS_TICKS = 1024,
  parameter bit ACTIVE_LOW_IN    = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] longPress,
  output logic                tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam int HW = LONG_PRESS_TICKS > 0 ? $clog2(LONG_PRESS_TICKS + 1) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SS = CW'(STABLE_SAMPLES);
  localparam logic [HW-1:0] LPT = HW'(LONG_PRESS_TICKS);
  localparam logic [CHANNELS-1:0] IDLE_IN = {CHANNELS{ACTIVE_LOW_IN}};
  typedef enum logic [1:0] {IDLE, RISING, HELD, FALLING} state_t;
  logic [PW-1:0] pre;
  logic [CHANNELS-1:0] meta, sync, s;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      meta <= IDLE_IN;
      sync <= IDLE_IN;
      pre  <= '0;
    end else begin
      meta <= in;
      sync <= meta;
      pre  <= pre == LAST ? '0 : pre + PW'(1);
    end
  assign s = sync ^ IDLE_IN;
  // gated by reset so a TICK_DIV of 1 still shows no strobe while held in reset
  assign tick = reset && pre == LAST;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t st;
    logic [CW-1:0] cnt, nxt;
    logic [HW-1:0] hold;
    logic fired, lvl, p, r, lp;
    // first differing sample counts as 1, so STABLE_SAMPLES==1 flips immediately
    assign nxt = (st == IDLE || st == HELD) ? CW'(1) : cnt + CW'(1);
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        st    <= IDLE;
        cnt   <= '0;
        hold  <= '0;
        fired <= 1'b0;
        lvl   <= 1'b0;
        p     <= 1'b0;
        r     <= 1'b0;
        lp    <= 1'b0;
      end else begin
        p  <= 1'b0;
        r  <= 1'b0;
        lp <= 1'b0;
        if (tick)
          case (st)
            IDLE, RISING:
              if (!s[i]) begin
                st  <= IDLE;
                cnt <= '0;
              end else if (nxt >= SS) begin
                st   <= HELD;
                cnt  <= '0;
                hold <= '0;
                lvl  <= 1'b1;
                p    <= 1'b1;
              end else begin
                st  <= RISING;
                cnt <= nxt;
              end
            default:
              if (s[i]) begin
                st  <= HELD;
                cnt <= '0;
                if (st == HELD && hold != LPT) hold <= hold + HW'(1);
                if (LONG_PRESS_TICKS > 0 && st == HELD && !fired && hold == LPT - HW'(1)) begin
                  lp    <= 1'b1;
                  fired <= 1'b1;
                end
              end else if (nxt >= SS) begin
                st    <= IDLE;
                cnt   <= '0;
                hold  <= '0;
                fired <= 1'b0;
                lvl   <= 1'b0;
                r     <= 1'b1;
              end else begin
                st  <= FALLING;
                cnt <= nxt;
              end
          endcase
      end
    assign level[i]     = lvl;
    assign pressed[i]   = p;
    assign released[i]  = r;
    assign longPress[i] = lp;
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios plus random input segments, checked every clock
// against a reference model that counts consecutive tick samples disagreeing with the level.
module tb_button_debouncer;
  localparam int CH = 3, TD = 4, SS = 3, LPT = 5;
  logic clock = 1'b0, reset = 1'b1;
  logic [CH-1:0] in = '0;
  logic [CH-1:0] level, pressed, released, longPress;
  logic tick;
  int compared = 0, mismatched = 0;
  logic [CH-1:0] ml, ep, er, el;
  logic [CH-1:0] dl[$];
  int run[CH], hold[CH];
  bit fired[CH];
  int k, cyc, n_tick, lat, n;
  int np[CH], nr[CH], nl[CH], pc[CH], lc[CH];

  button_debouncer #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_SAMPLES(SS),
    .LONG_PRESS_TICKS(LPT), .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .in(in), .level(level), .pressed(pressed),
    .released(released), .longPress(longPress), .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    ml = '0;
    k = 0;
    dl.delete();
    dl.push_back('1);
    dl.push_back('1);
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      hold[c] = 0;
      fired[c] = 1'b0;
    end
  endtask

  task automatic clear_counts();
    n_tick = 0;
    for (int c = 0; c < CH; c++) begin
      np[c] = 0; nr[c] = 0; nl[c] = 0; pc[c] = 0; lc[c] = 0;
    end
  endtask

  // one clock: model evaluates the cycle ending at this edge, then DUT outputs are compared
  task automatic step();
    logic [CH-1:0] s;
    s = ~dl[0];
    ep = '0; er = '0; el = '0;
    if (k % TD == TD - 1)
      for (int c = 0; c < CH; c++)
        if (s[c] != ml[c]) begin
          run[c]++;
          if (run[c] == SS) begin
            ml[c] = s[c];
            run[c] = 0;
            hold[c] = 0;
            if (s[c]) ep[c] = 1'b1;
            else begin er[c] = 1'b1; fired[c] = 1'b0; end
          end
        end else begin
          if (ml[c] && run[c] == 0 && hold[c] < LPT) begin
            hold[c]++;
            if (hold[c] == LPT && !fired[c]) begin el[c] = 1'b1; fired[c] = 1'b1; end
          end
          run[c] = 0;
        end
    void'(dl.pop_front());
    dl.push_back(in);
    k++;
    @(posedge clock);
    #1;
    chk("level", 32'(level), 32'(ml));
    chk("pressed", 32'(pressed), 32'(ep));
    chk("released", 32'(released), 32'(er));
    chk("longPress", 32'(longPress), 32'(el));
    chk("tick", 32'(tick), 32'(k % TD == TD - 1));
    cyc++;
    if (tick) n_tick++;
    for (int c = 0; c < CH; c++) begin
      if (pressed[c]) begin np[c]++; pc[c] = cyc; end
      if (released[c]) nr[c]++;
      if (longPress[c]) begin nl[c]++; lc[c] = cyc; end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_pulses", 32'(pressed | released | longPress), 0);
    chk("rst_tick", 32'(tick), 0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold", 32'({level, pressed, released, longPress, tick}), 0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    clear_counts();
    // 1: reset with all inputs low, release with all idle
    #3 apply_reset();
    in = '1;
    clear_counts();
    repeat (100) step();
    chk("t1_ticks", 32'(n_tick), 25);
    chk("t1_quiet", 32'(np[0] + np[1] + np[2] + nr[0] + nr[1] + nr[2] + nl[0] + nl[1] + nl[2]), 0);
    // 2: single press latency
    clear_counts();
    in[0] = 1'b0;
    lat = 0;
    while (!level[0] && lat < 40) begin step(); lat++; end
    chk("t2_latency_in_range", 32'(lat >= 11 && lat <= 15), 1);
    repeat (3) step();
    chk("t2_press_once", 32'(np[0]), 1);
    chk("t2_others_quiet", 32'(np[1] + np[2] + nr[0] + nl[1] + nl[2]), 0);
    // 3: bouncing input filtered, then one press
    clear_counts();
    for (int j = 0; j < 12; j++) begin
      in[1] = ~in[1];
      repeat (5) step();
    end
    chk("t3_bounce_quiet", 32'(np[1] + nr[1]), 0);
    in[1] = 1'b0;
    repeat (40) step();
    chk("t3_press_once", 32'(np[1]), 1);
    // 4: long press then release
    clear_counts();
    in[2] = 1'b0;
    repeat (12 * TD) step();
    in[2] = 1'b1;
    repeat (10 * TD) step();
    chk("t4_press", 32'(np[2]), 1);
    chk("t4_long_once", 32'(nl[2]), 1);
    chk("t4_release", 32'(nr[2]), 1);
    chk("t4_long_delay", 32'(lc[2] - pc[2]), 32'(LPT * TD));
    // 5: simultaneous presses on two channels
    in[1:0] = 2'b11;
    repeat (10 * TD) step();
    clear_counts();
    in[1:0] = 2'b00;
    repeat (8 * TD) step();
    chk("t5_press0", 32'(np[0]), 1);
    chk("t5_press1", 32'(np[1]), 1);
    chk("t5_same_cycle", 32'(pc[0]), 32'(pc[1]));
    // 6: reset during qualification; held button re-qualifies from zero
    in[0] = 1'b1;
    repeat (10 * TD) step();
    in[0] = 1'b0;
    repeat (2 * TD) step();
    apply_reset();
    clear_counts();
    lat = 0;
    while (!pressed[0] && lat < 40) begin step(); lat++; end
    chk("t6_ticks_before_press", 32'(n_tick), 3);
    chk("t6_press", 32'(np[0]), 1);
    // random segments: steady levels of random length and per-clock bounce bursts
    for (int j = 0; j < 60; j++) begin
      n = $urandom_range(1, 60);
      if ($urandom_range(0, 3) == 0)
        repeat (n) begin
          in = in ^ CH'($urandom_range(0, 7));
          step();
        end
      else begin
        in = CH'($urandom);
        repeat (n) step();
      end
      if (j == 30) apply_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
